// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: shared JTAG host command/state types and length helpers
package jtag_types_pkg;
  localparam int JTAG_MAX_LEN = 32;
  typedef enum logic [1:0] {OP_RESET, OP_IDLE, OP_IR_SCAN, OP_DR_SCAN} jtag_op_t;
  typedef enum logic [3:0] {
    H_IDLE, H_SYNC, H_RST, H_SEL, H_CAP, H_SHIFT, H_EXIT, H_UPD, H_RUN
  } host_state_t;
  // Index of the last shift/idle TCK; 0 and oversize lengths mean a full word.
  function automatic logic [5:0] last_idx(input logic [5:0] len);
    return (len == 6'd0 || len > 6'(JTAG_MAX_LEN)) ? 6'(JTAG_MAX_LEN - 1) : len - 6'd1;
  endfunction
  // Entry state of a command; an unknown TAP position needs one TMS=0 clock first.
  function automatic host_state_t first_state(input jtag_op_t op, input logic in_rti);
    return op == OP_RESET ? H_RST : !in_rti ? H_SYNC : op == OP_IDLE ? H_RUN : H_SEL;
  endfunction
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into TCK while enabled, with pre-edge rise/fall strobes
module jtag_tck_gen #(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic TRST,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);
  localparam int W = TCK_DIV > 1 ? $clog2(TCK_DIV) : 1;
  logic [W-1:0] cnt;
  logic tick;
  assign tick = en && cnt == W'(TCK_DIV - 1);
  assign rise = tick & ~tck;
  assign fall = tick & tck;
  // Phase counter; TCK parks low and the count restarts whenever disabled.
  always_ff @(posedge clk or negedge TRST)
    if (!TRST) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      tck <= tck ^ tick;
    end
endmodule

// File: rtl/jtag_host.sv
// jtag_host: command-driven JTAG scan engine producing TCK/TMS/TDI and capturing TDO
module jtag_host
  import jtag_types_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic        clk,
  input  logic        TRST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  jtag_op_t    cmd_op,
  input  logic [5:0]  cmd_len,
  input  logic [31:0] cmd_tdi,
  output logic        rsp_valid,
  output logic [31:0] rsp_tdo,
  output logic        TCK,
  output logic        TMS,
  output logic        TDI,
  input  logic        TDO,
  output logic        busy
);
  host_state_t state, fs;
  jtag_op_t op;
  logic in_rti, up, rise, fall, go;
  logic [5:0] cnt, last;
  logic [31:0] tdi;
  assign cmd_ready = up & ~busy;
  assign go = cmd_valid & cmd_ready;
  assign fs = first_state(cmd_op, in_rti);
  jtag_tck_gen #(.TCK_DIV(TCK_DIV)) u_tck (
    .clk(clk), .TRST(TRST), .en(busy), .tck(TCK), .rise(rise), .fall(fall)
  );
  // Controller: TMS/TDI for the next TCK are set on the edge where TCK falls.
  always_ff @(posedge clk or negedge TRST)
    if (!TRST) begin
      state     <= H_IDLE;
      op        <= OP_RESET;
      in_rti    <= 1'b0;
      up        <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_tdo   <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cnt       <= '0;
      last      <= '0;
      tdi       <= '0;
    end else begin
      up        <= 1'b1;
      rsp_valid <= 1'b0;
      if (go) begin
        state   <= fs;
        op      <= cmd_op;
        last    <= last_idx(cmd_len);
        tdi     <= cmd_tdi;
        rsp_tdo <= '0;
        busy    <= 1'b1;
        cnt     <= '0;
        TMS     <= fs == H_RST || fs == H_SEL;
        TDI     <= 1'b0;
      end else if (busy) begin
        if (rise && state == H_SHIFT) rsp_tdo[cnt[4:0]] <= TDO;
        if (fall)
          case (state)
            H_SYNC: begin
              in_rti <= 1'b1;
              state  <= first_state(op, 1'b1);
              TMS    <= op != OP_IDLE;
            end
            H_RST:
              if (cnt == 6'd5) begin
                in_rti    <= 1'b1;
                state     <= H_IDLE;
                busy      <= 1'b0;
                rsp_valid <= 1'b1;
                cnt       <= '0;
              end else begin
                cnt <= cnt + 6'd1;
                TMS <= cnt < 6'd4;
              end
            H_RUN:
              if (cnt == last) begin
                state     <= H_IDLE;
                busy      <= 1'b0;
                rsp_valid <= 1'b1;
                cnt       <= '0;
              end else cnt <= cnt + 6'd1;
            H_SEL:
              if (op == OP_IR_SCAN && cnt == 6'd0) cnt <= 6'd1;
              else begin
                state <= H_CAP;
                cnt   <= '0;
                TMS   <= 1'b0;
              end
            H_CAP:
              if (cnt == 6'd0) cnt <= 6'd1;
              else begin
                state <= H_SHIFT;
                cnt   <= '0;
                TMS   <= last == 6'd0;
                TDI   <= tdi[0];
              end
            H_SHIFT:
              if (cnt == last) begin
                state <= H_EXIT;
                TMS   <= 1'b1;
                TDI   <= 1'b0;
              end else begin
                cnt <= cnt + 6'd1;
                TMS <= cnt + 6'd1 == last;
                TDI <= tdi[cnt[4:0] + 5'd1];
              end
            H_EXIT: begin
              state <= H_UPD;
              TMS   <= 1'b0;
            end
            H_UPD: begin
              state     <= H_IDLE;
              busy      <= 1'b0;
              rsp_valid <= 1'b1;
              cnt       <= '0;
            end
            default: begin
              state <= H_IDLE;
              busy  <= 1'b0;
            end
          endcase
      end
    end
endmodule

// File: tb/tb_jtag_host.sv
// tb_jtag_host: table-driven checks of jtag_host against a TAP state model
module tb_jtag_host;
  import jtag_types_pkg::*;
  localparam logic [3:0] TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6,
    E2DR = 7, UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;
  logic clk = 0, TRST = 0, cmd_valid = 0, loop = 1;
  jtag_op_t cmd_op = OP_RESET;
  logic [5:0] cmd_len = 0;
  logic [31:0] cmd_tdi = 0, rsp_tdo;
  logic cmd_ready, rsp_valid, TCK, TMS, TDI, TDO, busy;
  logic [3:0] tap;
  logic [63:0] tms_log = 0;
  int ntck = 0, nshift = 0, nrsp = 0;
  int t0, s0, r0, total = 0, passed = 0;
  typedef struct {
    jtag_op_t op; logic [5:0] len; logic [31:0] tdi;
    int ntck; logic [63:0] tms; int nsh; logic [31:0] tdo;
  } vec_t;
  vec_t v[7];
  assign TDO = loop & TDI;
  jtag_host dut (
    .clk(clk), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_len(cmd_len), .cmd_tdi(cmd_tdi), .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo),
    .TCK(TCK), .TMS(TMS), .TDI(TDI), .TDO(TDO), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic m);
    case (s)
      TLR: return m ? TLR : RTI;
      RTI: return m ? SDR : RTI;
      SDR: return m ? SIR : CDR;
      CDR, SHDR: return m ? E1DR : SHDR;
      E1DR: return m ? UDR : PDR;
      PDR: return m ? E2DR : PDR;
      E2DR: return m ? UDR : SHDR;
      UDR, UIR: return m ? SDR : RTI;
      SIR: return m ? TLR : CIR;
      CIR, SHIR: return m ? E1IR : SHIR;
      E1IR: return m ? UIR : PIR;
      PIR: return m ? E2IR : PIR;
      default: return m ? UIR : SHIR;
    endcase
  endfunction
  // TAP model plus TMS history and shift-clock count, all on TCK rise.
  always @(posedge TCK or negedge TRST)
    if (!TRST) tap <= TLR;
    else begin
      tms_log <= {tms_log[62:0], TMS};
      ntck <= ntck + 1;
      if (tap == SHDR || tap == SHIR) nshift <= nshift + 1;
      tap <= tap_next(tap, TMS);
    end
  // Completion pulse counter.
  always @(negedge clk) if (rsp_valid) nrsp <= nrsp + 1;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
    else passed++;
  endtask
  task automatic snap();
    t0 = ntck; s0 = nshift; r0 = nrsp;
  endtask
  task automatic wait_rsp();
    bit ok = 0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    chk("rsp_seen", 64'(ok), 64'd1);
    if (ok) chk("end_pins", 64'({busy, cmd_ready, TCK}), 64'(3'b010));
  endtask
  task automatic check_run(input int n, input logic [63:0] tms, input int sh, input logic [31:0] tdo);
    int k;
    k = ntck - t0;
    chk("tck_count", 64'(k), 64'(n));
    chk("tms_seq", tms_log & ((64'd1 << k) - 64'd1), tms);
    chk("shift_clks", 64'(nshift - s0), 64'(sh));
    chk("rsp_tdo", 64'(rsp_tdo), 64'(tdo));
    chk("rsp_count", 64'(nrsp - r0), 64'd1);
    chk("tap_rti", 64'(tap), 64'(RTI));
  endtask
  task automatic issue(input jtag_op_t op, input logic [5:0] len, input logic [31:0] d);
    @(negedge clk);
    cmd_op = op; cmd_len = len; cmd_tdi = d; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
  endtask
  initial begin
    bit hit;
    v[0] = '{OP_RESET,   6'd0,  32'h0,        6,  64'(6'b111110),             0,  32'h0};
    v[1] = '{OP_DR_SCAN, 6'd8,  32'hA5,       13, 64'(13'b1000000000110),     8,  32'hA5};
    v[2] = '{OP_IR_SCAN, 6'd4,  32'hF,        10, 64'(10'b1100000110),        4,  32'hF};
    v[3] = '{OP_IDLE,    6'd3,  32'hFFFF,     3,  64'(3'b000),                0,  32'h0};
    v[4] = '{OP_DR_SCAN, 6'd40, 32'h12345678, 37, 64'({3'b100, 31'b0, 3'b110}), 32, 32'h12345678};
    v[5] = '{OP_DR_SCAN, 6'd1,  32'h1,        6,  64'(6'b100110),             1,  32'h1};
    v[6] = '{OP_DR_SCAN, 6'd3,  32'hFFFFFFFF, 8,  64'(8'b10000110),           3,  32'h7};
    repeat (3) @(negedge clk);
    chk("reset_pins", 64'({TCK, TMS, TDI, busy, cmd_ready, rsp_valid}), 64'(6'b010000));
    chk("reset_tdo", 64'(rsp_tdo), 64'd0);
    TRST = 1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 7; i++) begin
      snap();
      issue(v[i].op, v[i].len, v[i].tdi);
      wait_rsp();
      repeat (2) @(negedge clk);
      check_run(v[i].ntck, v[i].tms, v[i].nsh, v[i].tdo);
    end
    @(negedge clk); TRST = 0;
    repeat (2) @(negedge clk);
    chk("trst_pins", 64'({TCK, TMS, TDI, busy, cmd_ready, rsp_valid}), 64'(6'b010000));
    TRST = 1;
    @(posedge clk); #1;
    chk("ready_after_trst", 64'(cmd_ready), 64'd1);
    snap();
    issue(OP_DR_SCAN, 6'd1, 32'h1);
    chk("first_cycle", 64'({busy, TCK, TMS}), 64'(3'b100));
    @(negedge clk); chk("tck_low_phase", 64'(TCK), 64'd0);
    @(negedge clk); chk("tck_first_rise", 64'(TCK), 64'd1);
    wait_rsp();
    repeat (2) @(negedge clk);
    check_run(7, 64'(7'b0100110), 1, 32'h1);
    snap();
    issue(OP_DR_SCAN, 6'd0, 32'hFFFFFFFF);
    for (int i = 0; i < 5; i++) begin
      repeat (3) @(negedge clk);
      cmd_op = OP_IDLE; cmd_len = 6'd5; cmd_valid = 1;
      chk("ready_while_busy", 64'(cmd_ready), 64'd0);
      @(negedge clk); cmd_valid = 0;
    end
    wait_rsp();
    repeat (30) @(negedge clk);
    check_run(37, 64'({3'b100, 31'b0, 3'b110}), 32, 32'hFFFFFFFF);
    snap();
    issue(OP_DR_SCAN, 6'd32, 32'hDEADBEEF);
    hit = 0;
    for (int t = 0; t < 2000 && !hit; t++) begin
      @(negedge clk);
      hit = (ntck - t0) >= 20;
    end
    chk("reach_tck20", 64'(hit), 64'd1);
    TRST = 0;
    #1;
    chk("abort_pins", 64'({TCK, TMS, TDI, busy, cmd_ready, rsp_valid}), 64'(6'b010000));
    repeat (4) @(negedge clk);
    chk("abort_no_rsp", 64'(nrsp - r0), 64'd0);
    TRST = 1;
    #1;
    chk("ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge clk); #1;
    chk("ready_after_abort", 64'(cmd_ready), 64'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
